// File: rtl/ex_div_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// The execute stage drives operands and control (master); the divider returns
// the registered {remainder, quotient} result and its valid flag (slave).
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative 32-bit restoring radix-2 divider for DIV/DIVU.
// One quotient bit is produced per cycle.  Signed operations divide the
// operand magnitudes and then correct the signs of the quotient and the
// remainder.  The result is held while the execute stage keeps start_i high.
module ex_div (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_FREE        = 2'd0,
        ST_DIV_BY_ZERO = 2'd1,
        ST_ON          = 2'd2,
        ST_END         = 2'd3
    } state_t;

    // Two's-complement negate, modulo 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    // The most negative value wraps back to itself, which is what the
    // modulo-2^32 result arithmetic expects.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        logic [31:0] m;
        if (is_signed && v[31]) begin
            m = neg32(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Registered state
    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [64:0] work_r;
    logic [31:0] divisor_r;
    logic        signed_r;
    logic        dividend_neg_r;
    logic        divisor_neg_r;
    logic [63:0] result_r;
    logic        ready_r;

    // Next-state values
    state_t      state_s;
    logic [5:0]  cnt_s;
    logic [64:0] work_s;
    logic [31:0] divisor_s;
    logic        signed_s;
    logic        dividend_neg_s;
    logic        divisor_neg_s;
    logic [63:0] result_s;
    logic        ready_s;

    // Datapath helpers
    logic [32:0] diff_s;
    logic [31:0] quotient_s;
    logic [31:0] remainder_s;

    // Trial subtraction of the divisor from the current partial remainder;
    // diff_s[32] set means the subtraction borrowed (partial remainder too small).
    always_comb begin
        diff_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};
    end

    // Sign fix-up of the final quotient and remainder.
    always_comb begin
        quotient_s  = work_r[31:0];
        remainder_s = work_r[64:33];
        if (signed_r && (dividend_neg_r ^ divisor_neg_r)) begin
            quotient_s = neg32(work_r[31:0]);
        end else begin
            quotient_s = work_r[31:0];
        end
        if (signed_r && dividend_neg_r) begin
            remainder_s = neg32(work_r[64:33]);
        end else begin
            remainder_s = work_r[64:33];
        end
    end

    // Next-state, datapath update and output values for the divider FSM.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        work_s         = work_r;
        divisor_s      = divisor_r;
        signed_s       = signed_r;
        dividend_neg_s = dividend_neg_r;
        divisor_neg_s  = divisor_neg_r;
        result_s       = result_r;
        ready_s        = ready_r;

        case (state_r)
            ST_FREE: begin
                result_s = 64'd0;
                ready_s  = 1'b0;
                // A flush in the same cycle wins over a new request.
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == 32'd0) begin
                        state_s = ST_DIV_BY_ZERO;
                    end else begin
                        state_s        = ST_ON;
                        cnt_s          = 6'd0;
                        signed_s       = bus.signed_div_i;
                        dividend_neg_s = bus.signed_div_i & bus.opdata1_i[31];
                        divisor_neg_s  = bus.signed_div_i & bus.opdata2_i[31];
                        divisor_s      = mag32(bus.opdata2_i, bus.signed_div_i);
                        work_s         = {32'd0, mag32(bus.opdata1_i, bus.signed_div_i), 1'b0};
                    end
                end else begin
                    state_s = ST_FREE;
                end
            end

            ST_DIV_BY_ZERO: begin
                // Division by zero reports a zero quotient and zero remainder.
                state_s  = ST_END;
                result_s = 64'd0;
                ready_s  = 1'b1;
            end

            ST_ON: begin
                if (bus.annul_i) begin
                    state_s  = ST_FREE;
                    cnt_s    = 6'd0;
                    result_s = 64'd0;
                    ready_s  = 1'b0;
                end else if (cnt_r != 6'd32) begin
                    if (diff_s[32]) begin
                        // Divisor does not fit: shift in a 0 quotient bit.
                        work_s = {work_r[63:0], 1'b0};
                    end else begin
                        // Divisor fits: keep the difference, shift in a 1.
                        work_s = {diff_s[31:0], work_r[31:0], 1'b1};
                    end
                    cnt_s = cnt_r + 6'd1;
                end else begin
                    state_s  = ST_END;
                    cnt_s    = 6'd0;
                    result_s = {remainder_s, quotient_s};
                    ready_s  = 1'b1;
                end
            end

            ST_END: begin
                // Hold the result until the execute stage releases the request.
                if (!bus.start_i) begin
                    state_s  = ST_FREE;
                    result_s = 64'd0;
                    ready_s  = 1'b0;
                end else begin
                    state_s = ST_END;
                end
            end

            default: begin
                state_s  = ST_FREE;
                cnt_s    = 6'd0;
                result_s = 64'd0;
                ready_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; active-low reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_FREE;
            cnt_r          <= 6'd0;
            work_r         <= 65'd0;
            divisor_r      <= 32'd0;
            signed_r       <= 1'b0;
            dividend_neg_r <= 1'b0;
            divisor_neg_r  <= 1'b0;
            result_r       <= 64'd0;
            ready_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            work_r         <= work_s;
            divisor_r      <= divisor_s;
            signed_r       <= signed_s;
            dividend_neg_r <= dividend_neg_s;
            divisor_neg_r  <= divisor_neg_s;
            result_r       <= result_s;
            ready_r        <= ready_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, wrap case,
// divide by zero, annul, back-to-back requests and asynchronous reset.
module tb_ex_div;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_div_if bus ();

    ex_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a request (start held high) and return the number of edges after
    // E0 at which ready_o was first seen high, or -1 if it never rose.
    // Operands are scrambled right after E0: they must not be re-sampled.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.signed_div_i = ~sg;
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b + 32'd5;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Drop start_i and step to just after the next edge.
    task automatic drop_start();
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #12;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b result=%h, required ready=0 result=0",
                     bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_idle: ready=%b result=%h, required ready=0 result=0",
                     bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        do_div(1'b0, 32'd100, 32'd7, lat);
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL udiv_latency: got %0d edges, required 33", lat);
        end
        total++;
        if (bus.result_o !== 64'h00000002_0000000E) begin
            bad++;
            $display("FAIL udiv_100_7: got %h, required 000000020000000e", bus.result_o);
        end
        drop_start();
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL udiv_release: ready=%b result=%h, required ready=0 result=0",
                     bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_signed();
        int lat;
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
            bad++;
            $display("FAIL sdiv_m7_2: lat=%0d result=%h, required lat=33 result=fffffffffffffffd",
                     lat, bus.result_o);
        end
        drop_start();
        do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h00000001_FFFFFFFD) begin
            bad++;
            $display("FAIL sdiv_7_m2: lat=%0d result=%h, required lat=33 result=00000001fffffffd",
                     lat, bus.result_o);
        end
        drop_start();
    endtask

    task automatic test_wrap();
        int lat;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h00000000_80000000) begin
            bad++;
            $display("FAIL sdiv_wrap: lat=%0d result=%h, required lat=33 result=0000000080000000",
                     lat, bus.result_o);
        end
        drop_start();
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h80000000_00000000) begin
            bad++;
            $display("FAIL udiv_wrap: lat=%0d result=%h, required lat=33 result=8000000000000000",
                     lat, bus.result_o);
        end
        drop_start();
    endtask

    task automatic test_div_by_zero();
        int lat;
        do_div(1'b0, 32'h12345678, 32'd0, lat);
        total++;
        if (lat !== 1 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL dbz_first: lat=%0d result=%h, required lat=1 result=0",
                     lat, bus.result_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== 64'd0) begin
                bad++;
                $display("FAIL dbz_hold[%0d]: ready=%b result=%h, required ready=1 result=0",
                         i, bus.ready_o, bus.result_o);
            end
        end
        drop_start();
        total++;
        if (bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL dbz_release: ready=%b, required 0", bus.ready_o);
        end
    endtask

    task automatic test_annul();
        logic seen;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);              // E0
        repeat (9) @(posedge clk);   // E1..E9
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);              // E10 sees annul
        #1;
        total++;
        if (bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_ready: ready=%b, required 0", bus.ready_o);
        end
        // annul with start still high: FREE must not accept the request
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL annul_no_result: ready rose=%b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_div(1'b0, 32'd9, 32'd3, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h00000000_00000003) begin
            bad++;
            $display("FAIL b2b_9_3: lat=%0d result=%h, required lat=33 result=0000000000000003",
                     lat, bus.result_o);
        end
        drop_start();
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000010, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h0000000F_0FFFFFFF) begin
            bad++;
            $display("FAIL b2b_ffffffff_10: lat=%0d result=%h, required lat=33 result=0000000f0fffffff",
                     lat, bus.result_o);
        end
        // asynchronous reset while the result is held
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_end: ready=%b result=%h, required ready=0 result=0",
                     bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        int   lat;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);              // E0
        repeat (20) @(posedge clk);  // iteration 20
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid_op: ready=%b result=%h, required ready=0 result=0",
                     bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: activity=%b, required 0", seen);
        end
        do_div(1'b0, 32'd9, 32'd3, lat);
        total++;
        if (lat !== 33 || bus.result_o !== 64'h00000000_00000003) begin
            bad++;
            $display("FAIL reset_fresh_req: lat=%0d result=%h, required lat=33 result=0000000000000003",
                     lat, bus.result_o);
        end
        drop_start();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_wrap();
        test_div_by_zero();
        test_annul();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
